alu_arbiter_riscv: RTL
======================

ALU_ARBITER_RISCV -- requirements
Module: alu_arbiter_riscv

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning round-robin arbitration (0 = fixed priority, requester 0 wins).
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have, for k in {0,1}, port req<k>_valid_i  input  1  requester k presents an operation.
REQ-005 SHALL have, for each k, port req<k>_ready_o  output  1  operation accepted this cycle when valid&ready.
REQ-006 SHALL have, for each k, port req<k>_op_i  input  5  ALU opcode (alu_opcodes_pkg encoding).
REQ-007 SHALL have, for each k, ports req<k>_a_i and req<k>_b_i  input  32  operands.
REQ-008 SHALL have, for each k, port rsp<k>_valid_o  output  1  result slot k holds an undelivered result.
REQ-009 SHALL have, for each k, port rsp<k>_ready_i  input  1  requester k consumes the result when valid&ready.
REQ-010 SHALL have, for each k, ports rsp<k>_result_o (output, 32) and rsp<k>_flag_o (output, 1)  registered ALU result and branch flag.

Function
REQ-011 SHALL share exactly one combinational ALU between both requesters; at most one operation is accepted per cycle.
REQ-012 SHALL treat requester k as eligible when req<k>_valid_i=1 and slot k is empty or is being drained this cycle (rsp<k>_valid_o & rsp<k>_ready_i).
REQ-013 SHALL grant the single eligible requester when only one is eligible; SHALL grant none when none is eligible.
REQ-014 SHALL, with both eligible and RR_EN=1, grant the requester not granted most recently; with RR_EN=0, grant requester 0.
REQ-015 SHALL hold a 1-bit last-grant pointer updated only on an accepted operation; pointer reset value 1 (requester 0 wins first conflict).
REQ-016 SHALL drive req<k>_ready_o=1 only for the granted requester, combinationally in the same cycle.
REQ-017 SHALL, on acceptance at edge N, load ALU result_o and flag_o into slot k and assert rsp<k>_valid_o from cycle N+1 (latency 1).
REQ-018 SHALL keep rsp<k>_result_o/flag_o stable while rsp<k>_valid_o=1 and rsp<k>_ready_i=0.
REQ-019 SHALL, on simultaneous drain and new acceptance for slot k, overwrite the slot with the new result and keep rsp<k>_valid_o=1 (full throughput 1 op/cycle).
REQ-020 SHALL clear slot k valid on drain with no new acceptance.
REQ-021 SHALL drive slot results for unsupported opcodes exactly as the ALU does (result 0, flag 0).
REQ-022 SHALL keep a full, undrained slot k from blocking the other requester.
REQ-023 SHALL have a per-slot state machine EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain+accept or no drain.

Reset
REQ-024 SHALL, on rst_i=1 at any time (including mid-transfer), immediately set both slots EMPTY, rsp<k>_valid_o=0, rsp<k>_result_o=0, rsp<k>_flag_o=0, pointer=1.
REQ-025 SHALL drive req<k>_ready_o=0 while rst_i=1; in-flight operations are discarded, not replayed.

Structure
REQ-026 SHALL take opcode constants and a 5-bit opcode width constant from alu_opcodes_pkg; no new package.
REQ-027 SHALL instantiate alu_riscv exactly once as the sole sub-module, fed by a grant-selected operand/opcode mux.

Verification
REQ-028 Single: req0 ALU_ADD a=5 b=7, rsp0_ready_i=1 -> req0_ready_o=1 same cycle, rsp0_valid_o=1 next cycle, result=12, flag=0.
REQ-029 Conflict RR: both valid every cycle, ADD a=1/b=1 (req0), SUB a=9/b=4 (req1), both rsp ready -> grants alternate 0,1,0,1; results 2 and 5.
REQ-030 RR_EN=0, both valid continuously -> req0 granted every cycle, req1_ready_o stays 0.
REQ-031 Backpressure: req1 ALU_LTS a=0xFFFFFFFF b=0, rsp1_ready_i=0 -> flag=1 held; second req1 not accepted until rsp1_ready_i=1; req0 proceeds meanwhile.
REQ-032 Drain+accept: slot0 full, rsp0_ready_i=1 with new req0 XOR a=0xF0 b=0xFF -> rsp0_valid_o stays 1, result becomes 0x0F next cycle.
REQ-033 Reset mid-operation: assert rst_i asynchronously while slot1 full -> rsp1_valid_o=0 and result=0 before next edge; first post-reset conflict grants req0.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// alu_opcodes_pkg: ALU opcode width and encodings shared by the ALU and its arbiter.
// Comparison opcodes drive flag_o with the test outcome and also return it
// zero-extended on result_o. Encodings not listed here are unsupported and
// yield result 0, flag 0.
package alu_opcodes_pkg;
    localparam int ALU_OP_W = 5;
    typedef logic [ALU_OP_W-1:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 5'd0;
    localparam alu_op_t ALU_SUB = 5'd1;
    localparam alu_op_t ALU_XOR = 5'd2;
    localparam alu_op_t ALU_OR  = 5'd3;
    localparam alu_op_t ALU_AND = 5'd4;
    localparam alu_op_t ALU_SLL = 5'd5;
    localparam alu_op_t ALU_SRL = 5'd6;
    localparam alu_op_t ALU_SRA = 5'd7;
    localparam alu_op_t ALU_EQ  = 5'd8;
    localparam alu_op_t ALU_NE  = 5'd9;
    localparam alu_op_t ALU_LTS = 5'd10;
    localparam alu_op_t ALU_LTU = 5'd11;
    localparam alu_op_t ALU_GES = 5'd12;
    localparam alu_op_t ALU_GEU = 5'd13;
endpackage

// File: rtl/alu_riscv.sv
// alu_riscv: purely combinational RISC-V integer ALU.
// Ports: operator_i (opcode), operand_a_i/operand_b_i (32-bit operands),
//        result_o (32-bit result), flag_o (branch/compare outcome).
module alu_riscv
    import alu_opcodes_pkg::*;
(
    input  logic [ALU_OP_W-1:0] operator_i,
    input  logic [31:0]         operand_a_i,
    input  logic [31:0]         operand_b_i,
    output logic [31:0]         result_o,
    output logic                flag_o
);
    logic [4:0] w_shamt;
    logic       w_eq;
    logic       w_lts;
    logic       w_ltu;
    assign w_shamt = operand_b_i[4:0];
    assign w_eq    = operand_a_i == operand_b_i;
    assign w_lts   = $signed(operand_a_i) < $signed(operand_b_i);
    assign w_ltu   = operand_a_i < operand_b_i;
    always_comb begin
        result_o = '0;
        flag_o   = 1'b0;
        case (operator_i)
            ALU_ADD: result_o = operand_a_i + operand_b_i;
            ALU_SUB: result_o = operand_a_i - operand_b_i;
            ALU_XOR: result_o = operand_a_i ^ operand_b_i;
            ALU_OR:  result_o = operand_a_i | operand_b_i;
            ALU_AND: result_o = operand_a_i & operand_b_i;
            ALU_SLL: result_o = operand_a_i << w_shamt;
            ALU_SRL: result_o = operand_a_i >> w_shamt;
            ALU_SRA: result_o = 32'($signed(operand_a_i) >>> w_shamt);
            ALU_EQ:  begin flag_o = w_eq;   result_o = {31'b0, w_eq};   end
            ALU_NE:  begin flag_o = !w_eq;  result_o = {31'b0, !w_eq};  end
            ALU_LTS: begin flag_o = w_lts;  result_o = {31'b0, w_lts};  end
            ALU_LTU: begin flag_o = w_ltu;  result_o = {31'b0, w_ltu};  end
            ALU_GES: begin flag_o = !w_lts; result_o = {31'b0, !w_lts}; end
            ALU_GEU: begin flag_o = !w_ltu; result_o = {31'b0, !w_ltu}; end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_arbiter_riscv.sv
// alu_arbiter_riscv: two requesters share one ALU; each has a one-deep result slot.
// Ports: clk_i/rst_i (async active-high), req<k>_valid_i/ready_o/op_i/a_i/b_i
//        (operation handshake), rsp<k>_valid_o/ready_i/result_o/flag_o
//        (registered result handshake). RR_EN=1 round-robin, 0 fixed priority.
module alu_arbiter_riscv
    import alu_opcodes_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [ALU_OP_W-1:0] req0_op_i,
    input  logic [31:0]         req0_a_i,
    input  logic [31:0]         req0_b_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [ALU_OP_W-1:0] req1_op_i,
    input  logic [31:0]         req1_a_i,
    input  logic [31:0]         req1_b_i,
    output logic                rsp0_valid_o,
    input  logic                rsp0_ready_i,
    output logic [31:0]         rsp0_result_o,
    output logic                rsp0_flag_o,
    output logic                rsp1_valid_o,
    input  logic                rsp1_ready_i,
    output logic [31:0]         rsp1_result_o,
    output logic                rsp1_flag_o
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;
    logic [1:0]          r_state;
    logic [31:0]         r_result [2];
    logic [1:0]          r_flag;
    logic                r_last;
    logic [1:0]          w_drain;
    logic [1:0]          w_elig;
    logic [1:0]          w_gnt;
    logic [ALU_OP_W-1:0] w_op;
    logic [31:0]         w_a;
    logic [31:0]         w_b;
    logic [31:0]         w_result;
    logic                w_flag;
    // Bit k of r_state is slot k's state, so it doubles as the slot-full mask.
    assign w_drain = r_state & {rsp1_ready_i, rsp0_ready_i};
    assign w_elig  = {req1_valid_i, req0_valid_i} & (~r_state | w_drain);
    // r_last=1 means requester 1 won last, so requester 0 takes the next conflict.
    assign w_gnt[0] = w_elig[0] & (~w_elig[1] | ~RR_EN | r_last);
    assign w_gnt[1] = w_elig[1] & ~w_gnt[0];
    assign req0_ready_o = w_gnt[0] & ~rst_i;
    assign req1_ready_o = w_gnt[1] & ~rst_i;
    assign w_op = w_gnt[1] ? req1_op_i : req0_op_i;
    assign w_a  = w_gnt[1] ? req1_a_i  : req0_a_i;
    assign w_b  = w_gnt[1] ? req1_b_i  : req0_b_i;
    alu_riscv u_alu (
        .operator_i  (w_op),
        .operand_a_i (w_a),
        .operand_b_i (w_b),
        .result_o    (w_result),
        .flag_o      (w_flag)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= {S_EMPTY, S_EMPTY};
            r_result <= '{default: '0};
            r_flag   <= '0;
            r_last   <= 1'b1;
        end else begin
            if (|w_gnt) r_last <= w_gnt[1];
            for (int k = 0; k < 2; k++) begin
                if (w_gnt[k]) begin
                    r_state[k]  <= S_FULL;
                    r_result[k] <= w_result;
                    r_flag[k]   <= w_flag;
                end else if (w_drain[k]) begin
                    r_state[k]  <= S_EMPTY;
                end
            end
        end
    end
    assign rsp0_valid_o  = r_state[0] == S_FULL;
    assign rsp1_valid_o  = r_state[1] == S_FULL;
    assign rsp0_result_o = r_result[0];
    assign rsp1_result_o = r_result[1];
    assign rsp0_flag_o   = r_flag[0];
    assign rsp1_flag_o   = r_flag[1];
endmodule
